snake_body_engine: RTL and testbench



---
 rtl/snake_if.sv | 32 +++
 rtl/snake_body_engine.sv | 223 ++++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_if.sv
// Control/status bundle between the game logic, the VGA renderer and snake_body_engine.
interface snake_if #(
    parameter int X_W = 6,
    parameter int Y_W = 5,
    parameter int L_W = 7
);
    logic           start;
    logic           step;
    logic           dir_valid;
    logic [1:0]     dir_req;
    logic           grow;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic [L_W-1:0] length;
    logic [1:0]     state;
    logic           hit_wall;
    logic           hit_body;
    logic [X_W-1:0] q_x;
    logic [Y_W-1:0] q_y;
    logic           q_occ;
    logic           q_head;

    modport master (
        output start, step, dir_valid, dir_req, grow, q_x, q_y,
        input  head_x, head_y, length, state, hit_wall, hit_body, q_occ, q_head
    );

    modport slave (
        input  start, step, dir_valid, dir_req, grow, q_x, q_y,
        output head_x, head_y, length, state, hit_wall, hit_body, q_occ, q_head
    );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body engine: ring buffer of segment coordinates plus a grid occupancy bitmap.
// Optional macro SNAKE_WRAP_EN: the grid wraps at its edges instead of killing the snake.
module snake_body_engine #(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int X_W      = 6,
    parameter int Y_W      = 5,
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 3,
    parameter int L_W      = 7
) (
    input  logic   clk,
    input  logic   rst,
    snake_if.slave bus
);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int C_W   = $clog2(CELLS);
    localparam int P_W   = $clog2(MAX_LEN);
`ifdef SNAKE_WRAP_EN
    localparam bit WALLS = 1'b0;
`else
    localparam bit WALLS = 1'b1;
`endif
    localparam logic [1:0] DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_MOVE1, S_MOVE2, S_DEAD} state_t;
    state_t state_reg, state_next;

    logic [X_W-1:0]   ring_x [MAX_LEN];
    logic [Y_W-1:0]   ring_y [MAX_LEN];
    logic [CELLS-1:0] bitmap_reg;
    logic [P_W-1:0]   head_ptr_reg, tail_ptr_reg, init_cnt_reg, ring_wa;
    logic [X_W-1:0]   head_x_reg, tail_x_reg, nx_reg, nx, init_x, ring_wx;
    logic [Y_W-1:0]   head_y_reg, tail_y_reg, ny_reg, ny, init_y, ring_wy;
    logic [L_W-1:0]   length_reg;
    logic [1:0]       dir_reg, pend_reg, pend_next, state_out;
    logic             grow_reg, move_grow_reg, eff_grow;
    logic             wall_reg, body_reg, at_edge, body_hit;
    logic             hit_wall_reg, hit_body_reg, q_occ_reg, q_head_reg, q_in;
    logic             start_go, step_go, init_wr, init_last, commit, die, ring_we;

    function automatic logic [C_W-1:0] cell_idx(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return C_W'(y) * C_W'(GRID_W) + C_W'(x);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        start_go   = 1'b0;
        step_go    = 1'b0;
        init_wr    = 1'b0;
        commit     = 1'b0;
        die        = 1'b0;
        init_last  = (init_cnt_reg == P_W'(INIT_LEN - 1));
        case (state_reg)
            S_IDLE, S_DEAD: if (bus.start) begin
                start_go   = 1'b1;
                state_next = S_INIT;
            end
            S_INIT: begin
                init_wr = 1'b1;
                if (init_last) state_next = S_RUN;
            end
            S_RUN: if (bus.step) begin
                step_go    = 1'b1;
                state_next = S_MOVE1;
            end
            S_MOVE1: state_next = S_MOVE2;
            S_MOVE2: begin
                if (wall_reg || body_reg) begin
                    die        = 1'b1;
                    state_next = S_DEAD;
                end else begin
                    commit     = 1'b1;
                    state_next = S_RUN;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A request exactly opposite to the committed heading is dropped.
    always_comb begin
        pend_next = pend_reg;
        if (bus.dir_valid && (bus.dir_req != (dir_reg ^ 2'b01))) pend_next = bus.dir_req;
    end

    // Next head always holds the wrapped coordinate, so the bitmap index stays in range.
    always_comb begin
        nx      = head_x_reg;
        ny      = head_y_reg;
        at_edge = 1'b0;
        case (dir_reg)
            DIR_UP:    if (head_y_reg == '0) begin at_edge = 1'b1; ny = Y_W'(GRID_H - 1); end
                       else ny = head_y_reg - Y_W'(1);
            DIR_DOWN:  if (head_y_reg == Y_W'(GRID_H - 1)) begin at_edge = 1'b1; ny = '0; end
                       else ny = head_y_reg + Y_W'(1);
            DIR_LEFT:  if (head_x_reg == '0) begin at_edge = 1'b1; nx = X_W'(GRID_W - 1); end
                       else nx = head_x_reg - X_W'(1);
            default:   if (head_x_reg == X_W'(GRID_W - 1)) begin at_edge = 1'b1; nx = '0; end
                       else nx = head_x_reg + X_W'(1);
        endcase
        eff_grow = move_grow_reg && (length_reg < L_W'(MAX_LEN));
        body_hit = !(at_edge && WALLS) && bitmap_reg[cell_idx(nx, ny)]
                   && !((nx == tail_x_reg) && (ny == tail_y_reg) && !eff_grow);
    end

    assign init_x  = X_W'(GRID_W / 2 - INIT_LEN + 1) + X_W'(init_cnt_reg);
    assign init_y  = Y_W'(GRID_H / 2);
    assign ring_we = init_wr | commit;
    assign ring_wa = init_wr ? init_cnt_reg : head_ptr_reg + P_W'(1);
    assign ring_wx = init_wr ? init_x : nx_reg;
    assign ring_wy = init_wr ? init_y : ny_reg;
    assign q_in    = (int'(bus.q_x) < GRID_W) && (int'(bus.q_y) < GRID_H);

    // Tail coordinate is read registered; the tail pointer is stable for two cycles before any C1.
    always_ff @(posedge clk) begin
        if (ring_we) begin
            ring_x[ring_wa] <= ring_wx;
            ring_y[ring_wa] <= ring_wy;
        end
        tail_x_reg <= ring_x[tail_ptr_reg];
        tail_y_reg <= ring_y[tail_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_x_reg    <= '0;
            head_y_reg    <= '0;
            length_reg    <= '0;
            bitmap_reg    <= '0;
            head_ptr_reg  <= '0;
            tail_ptr_reg  <= '0;
            init_cnt_reg  <= '0;
            dir_reg       <= DIR_RIGHT;
            pend_reg      <= DIR_RIGHT;
            grow_reg      <= 1'b0;
            move_grow_reg <= 1'b0;
            nx_reg        <= '0;
            ny_reg        <= '0;
            wall_reg      <= 1'b0;
            body_reg      <= 1'b0;
            hit_wall_reg  <= 1'b0;
            hit_body_reg  <= 1'b0;
            q_occ_reg     <= 1'b0;
            q_head_reg    <= 1'b0;
        end else begin
            hit_wall_reg <= 1'b0;
            hit_body_reg <= 1'b0;
            pend_reg     <= pend_next;
            if (bus.grow) grow_reg <= 1'b1;
            if (start_go) begin
                bitmap_reg   <= '0;
                length_reg   <= '0;
                head_ptr_reg <= '0;
                tail_ptr_reg <= '0;
                init_cnt_reg <= '0;
                dir_reg      <= DIR_RIGHT;
                pend_reg     <= DIR_RIGHT;
            end
            if (init_wr) begin
                bitmap_reg[cell_idx(init_x, init_y)] <= 1'b1;
                head_x_reg   <= init_x;
                head_y_reg   <= init_y;
                head_ptr_reg <= init_cnt_reg;
                init_cnt_reg <= init_cnt_reg + P_W'(1);
                length_reg   <= length_reg + L_W'(1);
            end
            if (step_go) begin
                dir_reg       <= pend_next;
                move_grow_reg <= grow_reg | bus.grow;
                grow_reg      <= 1'b0;
            end
            if (state_reg == S_MOVE1) begin
                nx_reg   <= nx;
                ny_reg   <= ny;
                wall_reg <= at_edge && WALLS;
                body_reg <= body_hit;
            end
            if (die) begin
                hit_wall_reg <= wall_reg;
                hit_body_reg <= !wall_reg && body_reg;
            end
            // Tail clear precedes head set so moving into the vacated tail cell leaves it occupied.
            if (commit) begin
                if (!eff_grow) begin
                    bitmap_reg[cell_idx(tail_x_reg, tail_y_reg)] <= 1'b0;
                    tail_ptr_reg <= tail_ptr_reg + P_W'(1);
                end else begin
                    length_reg <= length_reg + L_W'(1);
                end
                bitmap_reg[cell_idx(nx_reg, ny_reg)] <= 1'b1;
                head_x_reg   <= nx_reg;
                head_y_reg   <= ny_reg;
                head_ptr_reg <= head_ptr_reg + P_W'(1);
            end
            q_occ_reg  <= q_in && bitmap_reg[cell_idx(bus.q_x, bus.q_y)];
            q_head_reg <= q_in && (length_reg != '0) && (bus.q_x == head_x_reg) && (bus.q_y == head_y_reg);
        end
    end

    always_comb begin
        case (state_reg)
            S_IDLE:  state_out = 2'b00;
            S_INIT:  state_out = 2'b01;
            S_DEAD:  state_out = 2'b11;
            default: state_out = 2'b10;
        endcase
    end

    assign bus.head_x   = head_x_reg;
    assign bus.head_y   = head_y_reg;
    assign bus.length   = length_reg;
    assign bus.state    = state_out;
    assign bus.hit_wall = hit_wall_reg;
    assign bus.hit_body = hit_body_reg;
    assign bus.q_occ    = q_occ_reg;
    assign bus.q_head   = q_head_reg;
endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine: stimulus queues timed expectations, a monitor checks them.
`timescale 1ns/1ps
module tb_snake_body_engine;
    localparam int X_W = 6, Y_W = 5, L_W = 7;
    localparam logic [1:0] UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snake_if #(.X_W(X_W), .Y_W(Y_W), .L_W(L_W)) bus ();

    snake_body_engine #(
        .GRID_W(40), .GRID_H(30), .X_W(X_W), .Y_W(Y_W),
        .MAX_LEN(64), .INIT_LEN(3), .L_W(L_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef enum int {K_STATE, K_HX, K_HY, K_LEN, K_QOCC, K_QHEAD, K_HITW, K_HITB} kind_t;
    typedef struct {
        int    due;
        kind_t kind;
        int    exp;
        string name;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int observe(input kind_t k);
        case (k)
            K_STATE: return int'(bus.state);
            K_HX:    return int'(bus.head_x);
            K_HY:    return int'(bus.head_y);
            K_LEN:   return int'(bus.length);
            K_QOCC:  return int'(bus.q_occ);
            K_QHEAD: return int'(bus.q_head);
            K_HITW:  return int'(bus.hit_wall);
            default: return int'(bus.hit_body);
        endcase
    endfunction

    // Monitor: every expectation whose due cycle has arrived is compared and retired.
    initial begin
        forever begin
            @(negedge clk);
            begin
                int i;
                i = 0;
                while (i < sb.size()) begin
                    if (sb[i].due <= cyc) begin
                        int got;
                        got = observe(sb[i].kind);
                        checks++;
                        if (sb[i].due < cyc) begin
                            failures++;
                            $display("FAIL %s: not sampled at due cycle %0d (now %0d)", sb[i].name, sb[i].due, cyc);
                        end else if (got != sb[i].exp) begin
                            failures++;
                            $display("FAIL %s: got %0d expected %0d at cycle %0d", sb[i].name, got, sb[i].exp, cyc);
                        end else begin
                            $display("[%0d] %s = %0d ok", cyc, sb[i].name, got);
                        end
                        sb.delete(i);
                    end else begin
                        i++;
                    end
                end
            end
        end
    end

    task automatic want(input kind_t k, input int v, input int dly, input string nm);
        exp_t e;
        e.due  = cyc + dly;
        e.kind = k;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic want_head(input int x, input int y, input int len, input int dly, input string nm);
        want(K_HX, x, dly, {nm, ".head_x"});
        want(K_HY, y, dly, {nm, ".head_y"});
        want(K_LEN, len, dly, {nm, ".length"});
    endtask

    task automatic query(input int x, input int y, input int occ, input int hd, input string nm);
        bus.q_x = X_W'(x);
        bus.q_y = Y_W'(y);
        tick();
        want(K_QOCC, occ, 0, {nm, ".q_occ"});
        want(K_QHEAD, hd, 0, {nm, ".q_head"});
    endtask

    task automatic pulse_step(input bit dv, input logic [1:0] d, input bit g);
        bus.dir_valid = dv;
        bus.dir_req   = d;
        bus.grow      = g;
        bus.step      = 1'b1;
        tick();
        bus.step      = 1'b0;
        bus.dir_valid = 1'b0;
        bus.grow      = 1'b0;
    endtask

    // Legal move: head, length and quiet hit lines are due two cycles after the step edge.
    task automatic move(input bit dv, input logic [1:0] d, input bit g,
                        input int ex, input int ey, input int elen, input string nm);
        pulse_step(dv, d, g);
        want(K_STATE, 2, 1, {nm, ".state_in_move"});
        want_head(ex, ey, elen, 2, nm);
        want(K_HITW, 0, 2, {nm, ".hit_wall"});
        want(K_HITB, 0, 2, {nm, ".hit_body"});
        ticks(2);
    endtask

    task automatic do_start(input string nm);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        want(K_STATE, 1, 0, {nm, ".state_init"});
        want(K_STATE, 2, 3, {nm, ".state_run"});
        want_head(20, 15, 3, 3, nm);
        ticks(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.step = 1'b0; bus.dir_valid = 1'b0;
        bus.dir_req = 2'b00; bus.grow = 1'b0; bus.q_x = '0; bus.q_y = '0;
        rst = 1'b1;
        ticks(2);
        want(K_STATE, 0, 0, "reset.state");
        want_head(0, 0, 0, 0, "reset");
        want(K_HITW, 0, 0, "reset.hit_wall");
        want(K_HITB, 0, 0, "reset.hit_body");
        want(K_QOCC, 0, 0, "reset.q_occ");
        rst = 1'b0;
        query(0, 0, 0, 0, "idle_q00");
        query(18, 15, 0, 0, "idle_q18");

        do_start("start1");
        query(18, 15, 1, 0, "init_tail");
        query(17, 15, 0, 0, "init_beyond_tail");
        query(20, 15, 1, 1, "init_head");
        query(45, 15, 0, 0, "outside_grid");

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        want(K_STATE, 2, 0, "start_in_run.state");
        want(K_LEN, 3, 0, "start_in_run.length");

        bus.dir_valid = 1'b1; bus.dir_req = LEFT;
        tick();
        bus.dir_valid = 1'b0;
        move(1'b0, 2'b00, 1'b0, 21, 15, 3, "reverse_dropped");
        query(18, 15, 0, 0, "old_tail_freed");
        query(19, 15, 1, 0, "new_tail");

        bus.grow = 1'b1;
        tick();
        bus.grow = 1'b0;
        move(1'b0, 2'b00, 1'b0, 22, 15, 4, "grow_step1");
        query(19, 15, 1, 0, "tail_held");
        move(1'b0, 2'b00, 1'b0, 23, 15, 4, "grow_step2");
        query(19, 15, 0, 0, "tail_moved");

        for (int x = 24; x <= 39; x++) move(1'b0, 2'b00, 1'b0, x, 15, 4, "run_right");
`ifdef SNAKE_WRAP_EN
        move(1'b0, 2'b00, 1'b0, 0, 15, 4, "wrap_edge");
`else
        pulse_step(1'b0, 2'b00, 1'b0);
        want(K_HITW, 1, 2, "wall.hit_wall");
        want(K_HITB, 0, 2, "wall.hit_body");
        want(K_STATE, 3, 2, "wall.state");
        want_head(39, 15, 4, 2, "wall");
        want(K_HITW, 0, 3, "wall.pulse_end");
        ticks(3);
        pulse_step(1'b0, 2'b00, 1'b0);
        want(K_HX, 39, 2, "dead_step_ignored.head_x");
        want(K_STATE, 3, 2, "dead_step_ignored.state");
        ticks(2);
        query(39, 15, 1, 1, "dead_frozen_head");
`endif

        do_reset();
        do_start("start_len4");
        move(1'b0, 2'b00, 1'b1, 21, 15, 4, "len4_grow");
        move(1'b1, UP, 1'b0, 21, 14, 4, "len4_up");
        move(1'b1, LEFT, 1'b0, 20, 14, 4, "len4_left");
        move(1'b1, DOWN, 1'b0, 20, 15, 4, "len4_down_into_tail");
        query(20, 15, 1, 1, "len4_head_cell");

        do_reset();
        do_start("start_len5");
        move(1'b0, 2'b00, 1'b1, 21, 15, 4, "len5_grow1");
        move(1'b0, 2'b00, 1'b1, 22, 15, 5, "len5_grow2");
        move(1'b1, UP, 1'b0, 22, 14, 5, "len5_up");
        move(1'b1, LEFT, 1'b0, 21, 14, 5, "len5_left");
        pulse_step(1'b1, DOWN, 1'b0);
        want(K_HITB, 1, 2, "body.hit_body");
        want(K_HITW, 0, 2, "body.hit_wall");
        want(K_STATE, 3, 2, "body.state");
        want_head(21, 14, 5, 2, "body");
        want(K_HITB, 0, 3, "body.pulse_end");
        ticks(3);

        do_start("restart_from_dead");
        query(22, 14, 0, 0, "bitmap_cleared");

        pulse_step(1'b0, 2'b00, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        want(K_STATE, 0, 0, "rst_in_move.state");
        want_head(0, 0, 0, 0, "rst_in_move");
        do_start("start_after_rst");
        move(1'b0, 2'b00, 1'b0, 21, 15, 3, "after_rst_step");

        ticks(4);
        while (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s: never checked, expected %0d due cycle %0d", sb[0].name, sb[0].exp, sb[0].due);
            void'(sb.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
